amba5_chi_link_ctrl: RTL
========================

// Module: amba5_chi_link_ctrl
// PURPOSE
//  Active CHI link-layer endpoint that drives the link activation handshake, the counterpart of
//  the passive link-state monitor. TX side raises txlinkactivereq and tracks L-credits; RX side
//  answers rxlinkactivereq with rxlinkactiveack and grants L-credits. Sits between the protocol
//  layer flit queues and the CHI pins.
// PARAMETERS
//  MAX_CREDITS  15  TX credit counter saturation value (CHI limit), 1..15
//  RX_CREDITS   4   RX buffer depth = max L-credits outstanding at the remote, 1..15
// PORTS
//  ACLK             in   1  clock
//  ARESETn          in   1  synchronous active-low reset
//  link_up_req      in   1  local request to keep the TX link up
//  txlinkactivereq  out  1  TX activation request to remote
//  txlinkactiveack  in   1  remote acknowledge of TX activation
//  rxlinkactivereq  in   1  remote RX activation request
//  rxlinkactiveack  out  1  local acknowledge of RX activation
//  tx_lcrdv         in   1  one L-credit granted by remote (pulse)
//  tx_flit_valid    in   1  protocol layer has a flit to send
//  tx_flit_go       out  1  flit sent this cycle, one credit consumed
//  tx_lcrd_return   out  1  LCrdReturn flit sent this cycle, one credit consumed
//  rx_lcrdv         out  1  one L-credit granted to remote (pulse)
//  rx_flitv         in   1  flit (incl. LCrdReturn) received, consumes one granted credit
//  tx_state         out  3  TxLnk_t current TX state
//  rx_state         out  3  RxLnk_t current RX state
//  proto_err        out  1  sticky protocol-violation flag
// BEHAVIOUR
//  Reset: tx_state=TxStop, rx_state=RxStop, all outputs 0, tx credit count 0, rx outstanding 0.
//  All outputs registered or decoded from registered state; no input->output comb path.
//  TX FSM (req = state in {TxAct,TxRun}):
//   TxStop : link_up_req && rx_state!=RxDeact -> TxAct
//   TxAct  : txlinkactiveack -> TxRun
//   TxRun  : tx_flit_go = tx_flit_valid && cnt>0; !link_up_req -> TxDeact (same-cycle flit still sent)
//   TxDeact: tx_flit_go=0; tx_lcrd_return=1 while cnt>0 (one per cycle);
//            cnt==0 && !txlinkactiveack -> TxStop
//  TX credit count: +1 on tx_lcrdv in TxRun/TxDeact, -1 on go or return; same-cycle +1/-1 -> net 0.
//   tx_lcrdv in TxStop/TxAct, or at cnt==MAX_CREDITS without a same-cycle decrement: ignored, proto_err=1.
//  RX FSM (ack = state in {RxAct,RxRun,RxDeact}):
//   RxStop : rxlinkactivereq -> RxAct
//   RxAct  : one cycle -> RxRun (ack already high)
//   RxRun  : rx_lcrdv=1 while outstanding<RX_CREDITS (one per cycle); !rxlinkactivereq -> RxDeact
//   RxDeact: no grants; outstanding==0 -> RxStop (ack drops next cycle)
//  RX outstanding: +1 on rx_lcrdv, -1 on rx_flitv; simultaneous -> net 0.
//   rx_flitv with outstanding==0, or outside RxRun/RxDeact: ignored, proto_err=1.
//  proto_err clears only on reset. Reset mid-operation drops req/ack next edge, discards credits.
// CONFIGURATION
//  CHI_LINK_AUTO_ACTIVATE_EN defined: TxStop->TxAct also when rxlinkactivereq=1 (remote wakes
//   local TX), and TxRun->TxDeact requires !link_up_req && !rxlinkactivereq.
//  Undefined: TX activation/deactivation governed by link_up_req only.
// STRUCTURE
//  chi5_link package: reuse TxLnk_t/RxLnk_t; add localparam CHI_LCRD_W=4 and chi_link_err_t.
//  Sub-module chi_lcrd_counter (inc/dec, saturation, zero/full flags), instantiated
//  for TX credits and RX outstanding.
// TESTING
//  1 link_up_req=1, ack after 2 cycles, 3 tx_lcrdv -> TxStop,TxAct,TxAct,TxRun; count=3.
//  2 TxRun cnt=2, tx_flit_valid held 4 cycles -> exactly 2 tx_flit_go, then stall with cnt=0.
//  3 link_up_req=0 at cnt=3 -> TxDeact, 3 tx_lcrd_return pulses, TxStop after ack low.
//  4 rxlinkactivereq=1, RX_CREDITS=4, no flits -> RxAct, 4 rx_lcrdv pulses, then none.
//  5 rxlinkactivereq=0 with 4 outstanding, 4 rx_flitv -> RxDeact, ack low after 4th flit.
//  6 tx_lcrdv in TxStop -> count stays 0, proto_err=1 until ARESETn=0.

Source files
------------

// File: rtl/amba5_chi_link_ctrl_pkg.sv
// Shared CHI link-layer types: TX/RX link states, credit counter width, error record.
package chi5_link_pkg;

  localparam int CHI_LCRD_W = 4;

  typedef enum logic [2:0] {
    TxStop  = 3'd0,
    TxAct   = 3'd1,
    TxRun   = 3'd2,
    TxDeact = 3'd3
  } TxLnk_t;

  typedef enum logic [2:0] {
    RxStop  = 3'd0,
    RxAct   = 3'd1,
    RxRun   = 3'd2,
    RxDeact = 3'd3
  } RxLnk_t;

  typedef struct packed {
    logic tx_lcrd_bad;
    logic rx_flit_bad;
  } chi_link_err_t;

endpackage

// File: rtl/amba5_chi_link_ctrl_lcrd_counter.sv
// L-credit up/down counter saturating at MAX and holding at zero; exposes zero/full flags.
module chi_lcrd_counter
  import chi5_link_pkg::*;
#(
  parameter int unsigned MAX = 15
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full
);

  localparam logic [CHI_LCRD_W-1:0] MAX_V = CHI_LCRD_W'(MAX);

  logic [CHI_LCRD_W-1:0] count_reg;

  // Simultaneous inc/dec cancels out.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      count_reg <= '0;
    end else if (inc && !dec && !full) begin
      count_reg <= count_reg + 1'b1;
    end else if (dec && !inc && !zero) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);
  assign full = (count_reg == MAX_V);

endmodule

// File: rtl/amba5_chi_link_ctrl.sv
// Active CHI link-layer endpoint: TX/RX activation handshakes and L-credit tracking.
// Optional feature macro CHI_LINK_AUTO_ACTIVATE_EN lets remote RX activation wake local TX.
module amba5_chi_link_ctrl
  import chi5_link_pkg::*;
#(
  parameter int unsigned MAX_CREDITS = 15,
  parameter int unsigned RX_CREDITS  = 4
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       link_up_req,
  output logic       txlinkactivereq,
  input  logic       txlinkactiveack,
  input  logic       rxlinkactivereq,
  output logic       rxlinkactiveack,
  input  logic       tx_lcrdv,
  input  logic       tx_flit_valid,
  output logic       tx_flit_go,
  output logic       tx_lcrd_return,
  output logic       rx_lcrdv,
  input  logic       rx_flitv,
  output logic [2:0] tx_state,
  output logic [2:0] rx_state,
  output logic       proto_err
);

  TxLnk_t        tx_state_reg;
  RxLnk_t        rx_state_reg;
  logic          tx_go_reg;
  logic          tx_ret_reg;
  logic          rx_lcrdv_reg;
  logic          err_reg;

  logic          tx_zero, tx_full, rx_zero, rx_full;
  logic          tx_want;
  logic          tx_go_next, tx_ret_next, tx_dec, tx_credit_phase, tx_inc;
  logic          rx_grant_next, rx_flit_phase, rx_flit_ok;
  chi_link_err_t err_now;

`ifdef CHI_LINK_AUTO_ACTIVATE_EN
  assign tx_want = link_up_req || rxlinkactivereq;
`else
  assign tx_want = link_up_req;
`endif

  // Credit consumption is decided here and registered, so the pulse and the decrement share an edge.
  assign tx_go_next      = (tx_state_reg == TxRun) && tx_flit_valid && !tx_zero;
  assign tx_ret_next     = (tx_state_reg == TxDeact) && !tx_zero;
  assign tx_dec          = tx_go_next || tx_ret_next;
  assign tx_credit_phase = (tx_state_reg == TxRun) || (tx_state_reg == TxDeact);
  assign tx_inc          = tx_lcrdv && tx_credit_phase && (!tx_full || tx_dec);

  assign rx_grant_next   = (rx_state_reg == RxRun) && !rx_full;
  assign rx_flit_phase   = (rx_state_reg == RxRun) || (rx_state_reg == RxDeact);
  assign rx_flit_ok      = rx_flitv && rx_flit_phase && !rx_zero;

  assign err_now.tx_lcrd_bad = tx_lcrdv && (!tx_credit_phase || (tx_full && !tx_dec));
  assign err_now.rx_flit_bad = rx_flitv && !rx_flit_ok;

  chi_lcrd_counter #(.MAX(MAX_CREDITS)) u_tx_cnt (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .inc     (tx_inc),
    .dec     (tx_dec),
    .zero    (tx_zero),
    .full    (tx_full)
  );

  chi_lcrd_counter #(.MAX(RX_CREDITS)) u_rx_cnt (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .inc     (rx_grant_next),
    .dec     (rx_flit_ok),
    .zero    (rx_zero),
    .full    (rx_full)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tx_state_reg <= TxStop;
      tx_go_reg    <= 1'b0;
      tx_ret_reg   <= 1'b0;
    end else begin
      tx_go_reg  <= tx_go_next;
      tx_ret_reg <= tx_ret_next;
      case (tx_state_reg)
        TxStop:  if (tx_want && rx_state_reg != RxDeact) tx_state_reg <= TxAct;
        TxAct:   if (txlinkactiveack) tx_state_reg <= TxRun;
        TxRun:   if (!tx_want) tx_state_reg <= TxDeact;
        TxDeact: if (tx_zero && !txlinkactiveack) tx_state_reg <= TxStop;
        default: tx_state_reg <= TxStop;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rx_state_reg <= RxStop;
      rx_lcrdv_reg <= 1'b0;
    end else begin
      rx_lcrdv_reg <= rx_grant_next;
      case (rx_state_reg)
        RxStop:  if (rxlinkactivereq) rx_state_reg <= RxAct;
        RxAct:   rx_state_reg <= RxRun;
        RxRun:   if (!rxlinkactivereq) rx_state_reg <= RxDeact;
        RxDeact: if (rx_zero) rx_state_reg <= RxStop;
        default: rx_state_reg <= RxStop;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_reg | (|err_now);
    end
  end

  assign txlinkactivereq = (tx_state_reg == TxAct) || (tx_state_reg == TxRun);
  assign rxlinkactiveack = (rx_state_reg != RxStop);
  assign tx_flit_go      = tx_go_reg;
  assign tx_lcrd_return  = tx_ret_reg;
  assign rx_lcrdv        = rx_lcrdv_reg;
  assign tx_state        = tx_state_reg;
  assign rx_state        = rx_state_reg;
  assign proto_err       = err_reg;

endmodule
